// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: mode codes, FSM states
// and the default trap vector.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/pc_if.sv
// Control and address bundle between decode/execute and the PC generator.
interface pc_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
);

  logic             load;
  logic [1:0]       pc_mode;
  logic             branch_taken;
  logic [XLEN-1:0]  imm_ext;
  logic [XLEN-1:0]  rs1_val;
  logic             trap;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic             misaligned;
  logic [XLEN-1:0]  bad_addr;
  logic [CNT_W-1:0] instret;

  modport master (
    output load, pc_mode, branch_taken, imm_ext, rs1_val, trap,
    input  pc, pc_plus4, misaligned, bad_addr, instret
  );

  modport slave (
    input  load, pc_mode, branch_taken, imm_ext, rs1_val, trap,
    output pc, pc_plus4, misaligned, bad_addr, instret
  );

endinterface

// File: rtl/instret_counter.sv
// Free-running event counter with increment enable and synchronous clear;
// wraps to zero at 2^Width.
module instret_counter #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: next-target selection, misaligned-target fault
// state and retired-instruction count.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned     CNT_W        = 64
) (
  input logic clk,
  input logic Sync_reset,
  pc_if.slave bus
);

  localparam logic [XLEN-1:0] Four = XLEN'(4);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic [XLEN-1:0] seq_target, jalr_sum, target;
  logic            target_misaligned;
  logic            retire;

  assign seq_target = pc_q + Four;
  assign jalr_sum   = bus.rs1_val + bus.imm_ext;

  always_comb begin
    target = seq_target;
    unique case (pc_mode_e'(bus.pc_mode))
      PC_SEQ:    target = seq_target;
      PC_BRANCH: target = bus.branch_taken ? (pc_q + bus.imm_ext) : seq_target;
      PC_JAL:    target = pc_q + bus.imm_ext;
      PC_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
    endcase
  end

  // Sequential fetch always stays aligned, so it never raises a fault.
  assign target_misaligned = (pc_mode_e'(bus.pc_mode) != PC_SEQ) && (target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    bad_addr_d = bad_addr_q;
    retire     = 1'b0;
    if (bus.trap) begin
      // Trap overrides stall and fault and suppresses any fault this cycle.
      pc_d    = TRAP_VECTOR;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && bus.load) begin
      if (target_misaligned) begin
        bad_addr_d = target;
        state_d    = ST_FAULT;
      end else begin
        pc_d   = target;
        retire = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Sync_reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  instret_counter #(
    .Width (CNT_W)
  ) u_instret (
    .clk_i   (clk),
    .clr_i   (Sync_reset),
    .inc_i   (retire),
    .count_o (bus.instret)
  );

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = seq_target;
  assign bus.misaligned = (state_q == ST_FAULT);
  assign bus.bad_addr   = bad_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized checks of pc_gen against a behavioural PC model,
// plus a narrow 8-bit / 4-bit-counter instance for wrap behaviour.
module tb_pc_gen;

  localparam logic [31:0] Rv32 = 32'h0000_0000;
  localparam logic [31:0] Tv32 = 32'h0000_0100;
  localparam logic [7:0]  Tv8  = 8'h40;

  logic clk = 1'b0;
  logic rst32 = 1'b1;
  logic rst8  = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference state for the 32-bit instance.
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_bad;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  pc_if #(.XLEN(32), .CNT_W(64)) b32 ();
  pc_if #(.XLEN(8),  .CNT_W(4))  b8 ();

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (Rv32),
    .TRAP_VECTOR  (Tv32),
    .CNT_W        (64)
  ) u_dut32 (
    .clk        (clk),
    .Sync_reset (rst32),
    .bus        (b32.slave)
  );

  pc_gen #(
    .XLEN         (8),
    .RESET_VECTOR (8'h00),
    .TRAP_VECTOR  (Tv8),
    .CNT_W        (4)
  ) u_dut8 (
    .clk        (clk),
    .Sync_reset (rst8),
    .bus        (b8.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},       64'(b32.pc),         64'(m_pc));
    chk({tag, ".pc_plus4"}, 64'(b32.pc_plus4),   64'(m_pc + 32'd4));
    chk({tag, ".mis"},      64'(b32.misaligned), 64'(m_fault));
    chk({tag, ".bad"},      64'(b32.bad_addr),   64'(m_bad));
    chk({tag, ".instret"},  b32.instret,         m_cnt);
  endtask

  // Drives one edge of the 32-bit DUT, advances the model, then checks.
  task automatic step32(input string tag, input logic rst, input logic ld,
                        input logic [1:0] mode, input logic tk, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic tr);
    logic [31:0] tgt;
    @(negedge clk);
    rst32 = rst; b32.load = ld; b32.pc_mode = mode; b32.branch_taken = tk;
    b32.imm_ext = imm; b32.rs1_val = rs1; b32.trap = tr;
    if (rst) begin
      m_pc = Rv32; m_fault = 1'b0; m_bad = '0; m_cnt = '0;
    end else if (tr) begin
      m_pc = Tv32; m_fault = 1'b0;
    end else if (!m_fault && ld) begin
      case (mode)
        2'd0:    tgt = m_pc + 32'd4;
        2'd1:    tgt = tk ? m_pc + imm : m_pc + 32'd4;
        2'd2:    tgt = m_pc + imm;
        default: tgt = (rs1 + imm) & 32'hFFFF_FFFE;
      endcase
      if (mode != 2'd0 && (tgt % 4) != 0) begin
        m_fault = 1'b1; m_bad = tgt;
      end else begin
        m_pc = tgt; m_cnt = m_cnt + 64'd1;
      end
    end
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic step8(input logic rst, input logic ld, input logic [1:0] mode,
                       input logic [7:0] imm, input logic tr);
    @(negedge clk);
    rst8 = rst; b8.load = ld; b8.pc_mode = mode; b8.branch_taken = 1'b0;
    b8.imm_ext = imm; b8.rs1_val = '0; b8.trap = tr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] imm;
    b8.load = 1'b0; b8.pc_mode = 2'd0; b8.branch_taken = 1'b0;
    b8.imm_ext = '0; b8.rs1_val = '0; b8.trap = 1'b0;

    // Reset and sequential fetch.
    step32("reset", 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reset.pc_plus4", 64'(b32.pc_plus4), 64'h4);
    for (int i = 0; i < 3; i++) step32("seq", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("seq3.pc", 64'(b32.pc), 64'hC);
    chk("seq3.instret", b32.instret, 64'd3);

    // Branch taken / not taken from 0x10.
    step32("seq", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    step32("br_t", 1'b0, 1'b1, 2'd1, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0);
    chk("br_taken.pc", 64'(b32.pc), 64'h8);
    step32("jal", 1'b0, 1'b1, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0);
    step32("br_nt", 1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0);
    chk("br_not_taken.pc", 64'(b32.pc), 64'h14);

    // JALR bit-0 clear, misaligned fault, frozen pc, trap exit.
    step32("jalr_ok", 1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h101, 1'b0);
    chk("jalr_ok.pc", 64'(b32.pc), 64'h100);
    step32("jalr_bad", 1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h102, 1'b0);
    chk("fault.mis", 64'(b32.misaligned), 64'h1);
    chk("fault.bad", 64'(b32.bad_addr), 64'h102);
    for (int i = 0; i < 5; i++) step32("frozen", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("frozen.pc", 64'(b32.pc), 64'h100);
    step32("trap", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("trap.mis", 64'(b32.misaligned), 64'h0);

    // Stall with JAL pending, then a single jump.
    for (int i = 0; i < 4; i++) step32("stall", 1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
    step32("stall_go", 1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
    chk("stall_go.pc", 64'(b32.pc), 64'h140);
    step32("stall_after", 1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);

    // Reset while faulted; trap beats a simultaneous misaligned JALR.
    step32("jalr_bad2", 1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h3, 1'b0);
    chk("fault2.bad", 64'(b32.bad_addr), 64'h2);
    step32("rst_in_fault", 1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 32'h3, 1'b0);
    chk("rst_in_fault.pc", 64'(b32.pc), 64'h0);
    step32("trap_vs_bad", 1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h6, 1'b1);
    chk("trap_vs_bad.pc", 64'(b32.pc), 64'h100);
    chk("trap_vs_bad.mis", 64'(b32.misaligned), 64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      imm = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) imm = imm | 32'($urandom_range(1, 3));
      step32("rand", $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), imm, $urandom,
             $urandom_range(0, 7) == 0);
    end

    // Narrow instance: pc wrap at 2^8 and instret wrap at 2^4.
    step8(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("w8.reset.pc", 64'(b8.pc), 64'h0);
    chk("w8.reset.instret", 64'(b8.instret), 64'h0);
    step8(1'b0, 1'b1, 2'd2, 8'hFC, 1'b0);
    chk("w8.jal.pc", 64'(b8.pc), 64'hFC);
    chk("w8.jal.pc_plus4", 64'(b8.pc_plus4), 64'h0);
    step8(1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    chk("w8.wrap.pc", 64'(b8.pc), 64'h0);
    chk("w8.wrap.mis", 64'(b8.misaligned), 64'h0);
    for (int i = 0; i < 14; i++) step8(1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    chk("w8.cnt_wrap.instret", 64'(b8.instret), 64'h0);
    chk("w8.cnt_wrap.pc", 64'(b8.pc), 64'h38);
    step8(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("w8.trap.pc", 64'(b8.pc), 64'(Tv8));
    chk("w8.trap.instret", 64'(b8.instret), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V core's fetch stage. It is the successor to the fixed 32-bit PC register: it adds configurable width and reset vector, stall, branch/JAL/JALR target selection, trap redirection and a misaligned-target fault state. It also keeps a retired-instruction counter. It sits between the decode/execute control signals and the instruction memory address port.

## Interface
- XLEN, 32: PC and operand width in bits.
- RESET_VECTOR, 0: PC value after reset. Must be 4-byte aligned.
- TRAP_VECTOR, 32'h0000_0100: PC value loaded on a trap. Must be 4-byte aligned.
- CNT_W, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- Sync_reset  in  1  synchronous, active-high reset.
- load  in  1  advance enable; 0 = stall (all state holds).
- pc_mode  in  2  0 SEQ, 1 BRANCH, 2 JAL, 3 JALR.
- branch_taken  in  1  qualifies BRANCH mode.
- imm_ext  in  XLEN  sign-extended immediate.
- rs1_val  in  XLEN  JALR base register value.
- trap  in  1  redirect to TRAP_VECTOR.
- pc  out  XLEN  current fetch address (registered).
- pc_plus4  out  XLEN  pc + 4; the link value. Combinational from pc.
- misaligned  out  1  high while in FAULT.
- bad_addr  out  XLEN  offending target latched on fault entry.
- instret  out  CNT_W  retired-instruction count.

## Operation
Target selection, combinational, all arithmetic modulo 2^XLEN:
- SEQ: pc + 4.
- BRANCH: pc + imm_ext when branch_taken = 1; pc + 4 when branch_taken = 0.
- JAL: pc + imm_ext.
- JALR: (rs1_val + imm_ext) with bit 0 cleared.

Alignment check:
- A target is misaligned when target[1:0] != 0, evaluated after the JALR bit-0 clear.
- SEQ targets are never misaligned.

States (2):
- RUN: normal sequencing.
- FAULT: pc frozen on the faulting instruction's address.

Per-edge priority, highest first:
1. Sync_reset: pc = RESET_VECTOR, state = RUN, bad_addr = 0, instret = 0.
2. trap: pc = TRAP_VECTOR, state = RUN. Acts regardless of load or state. bad_addr holds; instret does not increment.
3. state = FAULT: all state holds. Only trap or reset leave FAULT.
4. load = 0: all state holds (stall).
5. RUN, load = 1, target aligned: pc = target, instret += 1.
6. RUN, load = 1, target misaligned: pc holds, bad_addr = target, state = FAULT. instret does not increment.

Boundary rules:
- pc wraps from 2^XLEN−4 to 0 on SEQ with no flag.
- instret wraps to 0 at 2^CNT_W.
- trap and a misaligned target in the same cycle: trap wins and no fault is recorded.

## Timing
- pc, state, bad_addr and instret are all registered and update on the rising clk edge.
- Reset values: pc = RESET_VECTOR, misaligned = 0, bad_addr = 0, instret = 0, pc_plus4 = RESET_VECTOR + 4.
- Redirect latency: 1 cycle. Inputs sampled at edge N set pc after edge N.
- misaligned rises in the cycle after the offending edge and stays high until the edge that samples trap = 1 or Sync_reset = 1.
- Reset asserted mid-fault or mid-stall takes effect at the next edge. No state survives it.
- No handshake. The upstream holds pc_mode and operands stable only for the sampling edge.

## Structure
- Shared package pc_pkg holds:
  - pc_mode codes: PC_SEQ, PC_BRANCH, PC_JAL, PC_JALR.
  - State enum: ST_RUN, ST_FAULT.
  - Default TRAP_VECTOR constant.
- One sub-module, instret_counter: a CNT_W-bit counter with inc and sync clear, reused later for the cycle CSR.
- Target mux, alignment check and FSM stay in pc_gen.

## Test plan
- Reset, then 3 cycles with load = 1 in SEQ → pc = 0, 4, 8, 12; instret = 3.
- BRANCH with imm_ext = −8 at pc = 0x10: branch_taken = 1 → pc = 0x08. Same stimulus with branch_taken = 0 → pc = 0x14.
- JALR with rs1_val = 0x101, imm_ext = 0 → pc = 0x100. JALR with rs1_val = 0x102 → misaligned = 1, bad_addr = 0x102, pc unchanged; pc stays frozen 5 cycles despite load = 1; trap → pc = TRAP_VECTOR, misaligned = 0.
- Stall: load = 0 for 4 cycles with pc_mode = JAL → pc and instret unchanged; load = 1 → jump taken once.
- XLEN = 8, pc = 0xFC, SEQ → pc = 0x00. CNT_W = 4, 16 retirements → instret = 0.
- Sync_reset asserted while in FAULT, and trap asserted together with a misaligned JALR → RESET_VECTOR and TRAP_VECTOR respectively, with misaligned = 0.
